// File: rtl/reader_slot_ctrl_pkg.sv
// reader_slot_ctrl_pkg: shared command codes, slot-result encoding and FSM states
//   CMD_*  : cmd_head codes, identical to the tag-side command decoder
//   SR_*   : slot_result encoding (bit 1 set means collision)
//   ST_*   : controller state encoding
package reader_slot_ctrl_pkg;
  localparam logic [7:0] CMD_QUERY    = 8'h01;
  localparam logic [7:0] CMD_QUERYREP = 8'h02;
  localparam logic [7:0] CMD_DIVIDE   = 8'h03;
  localparam logic [7:0] CMD_DISPERSE = 8'h04;
  localparam logic [7:0] CMD_SHRINK   = 8'h05;
  localparam logic [1:0] SR_IDLE      = 2'b00;
  localparam logic [1:0] SR_SINGLE    = 2'b01;
  localparam logic [1:0] SR_COLL_MASK = 2'b10;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT      = 3'd2;
  localparam logic [2:0] ST_DECIDE    = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [14:0] PEND_MAX    = 15'h7FFF;
  typedef enum logic [1:0] {RES_IDLE, RES_SINGLE, RES_COLL} res_e;
  // Both 10 and 11 are collisions.
  function automatic res_e classify(input logic [1:0] r);
    return (r & SR_COLL_MASK) != 2'b00 ? RES_COLL : (r == SR_SINGLE ? RES_SINGLE : RES_IDLE);
  endfunction
endpackage

// File: rtl/reader_slot_ctrl_if.sv
// reader_slot_ctrl_if: control/response bundle between reader slot controller and its environment
//   master : controller side (consumes start/abort/cmd_ready/results, drives command + status)
//   slave  : environment side (encoder, receiver, host)
interface reader_slot_ctrl_if;
  logic        start;
  logic        abort;
  logic        cmd_ready;
  logic        result_valid;
  logic [1:0]  slot_result;
  logic        cmd_valid;
  logic [7:0]  cmd_head;
  logic        divide_position;
  logic        busy;
  logic        done;
  logic [15:0] tag_count;
  logic [14:0] pending;
  modport master (
    input  start, abort, cmd_ready, result_valid, slot_result,
    output cmd_valid, cmd_head, divide_position, busy, done, tag_count, pending
  );
  modport slave (
    output start, abort, cmd_ready, result_valid, slot_result,
    input  cmd_valid, cmd_head, divide_position, busy, done, tag_count, pending
  );
endinterface

// File: rtl/reader_slot_ctrl_resp_timer.sv
// resp_timer: counts cycles spent waiting for a slot response
//   clk, rst_n : clock, async active-low reset
//   i_clear    : synchronous clear (held while not waiting)
//   i_enable   : count while waiting
//   o_expired  : high on the TIMEOUT-th enabled cycle
module resp_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] r_count;
  assign o_expired = i_enable && r_count == W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_enable && !o_expired) r_count <= r_count + 1'b1;
  end
endmodule

// File: rtl/reader_slot_ctrl.sv
// reader_slot_ctrl: inventory-round slot controller
//   clk, rst_n : clock, async active-low reset
//   bus        : master side of reader_slot_ctrl_if
//                in : start, abort, cmd_ready, result_valid, slot_result
//                out: cmd_valid, cmd_head, divide_position, busy, done, tag_count, pending
module reader_slot_ctrl
  import reader_slot_ctrl_pkg::*;
#(
  parameter int COLL_LIMIT = 3,
  parameter int IDLE_LIMIT = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic clk,
  input  logic rst_n,
  reader_slot_ctrl_if.master bus
);
  localparam int CW = $clog2(COLL_LIMIT + 1);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  logic [2:0]    r_state, w_state;
  logic [CW-1:0] r_coll_run, w_coll_run, w_coll_inc;
  logic [IW-1:0] r_idle_run, w_idle_run, w_idle_inc;
  logic [15:0]   r_tag_count, w_tag_count;
  logic [14:0]   r_pending, w_pending, w_pend_inc, w_pend_dbl, w_pend_dec, w_pend_half;
  logic [7:0]    r_cmd_head, w_cmd_head;
  logic [1:0]    r_result, w_result;
  logic          r_cmd_valid, w_cmd_valid, r_done, w_done, r_busy;
  logic          w_expired, w_tmr_clear, w_tmr_en;
  res_e          w_res;
  assign w_tmr_en    = r_state == ST_WAIT;
  assign w_tmr_clear = !w_tmr_en;
  resp_timer #(.TIMEOUT(TIMEOUT)) u_resp_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );
  assign w_res       = classify(r_result);
  assign w_coll_inc  = r_coll_run + 1'b1;
  assign w_idle_inc  = r_idle_run + 1'b1;
  assign w_pend_inc  = r_pending == PEND_MAX ? PEND_MAX : r_pending + 15'd1;
  assign w_pend_dbl  = r_pending[14] ? PEND_MAX : {r_pending[13:0], 1'b0};
  assign w_pend_dec  = r_pending - 15'd1;
  // Widened so 0x7FFF + 1 does not wrap before halving.
  assign w_pend_half = 15'((16'(r_pending) + 16'd1) >> 1);
  always_comb begin
    w_state     = r_state;
    w_cmd_valid = r_cmd_valid;
    w_cmd_head  = r_cmd_head;
    w_done      = 1'b0;
    w_tag_count = r_tag_count;
    w_pending   = r_pending;
    w_coll_run  = r_coll_run;
    w_idle_run  = r_idle_run;
    w_result    = r_result;
    if (r_state != ST_IDLE && bus.abort) begin
      w_state     = ST_IDLE;
      w_cmd_valid = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          w_state     = ST_ISSUE;
          w_cmd_valid = 1'b1;
          w_cmd_head  = CMD_QUERY;
          w_tag_count = '0;
          w_pending   = 15'd1;
          w_coll_run  = '0;
          w_idle_run  = '0;
        end
        ST_ISSUE: if (bus.cmd_ready) begin
          w_state     = ST_WAIT;
          w_cmd_valid = 1'b0;
        end
        ST_WAIT: if (bus.result_valid || w_expired) begin
          w_state  = ST_DECIDE;
          w_result = bus.result_valid ? bus.slot_result : SR_IDLE;
        end
        ST_DECIDE: begin
          if (w_res == RES_SINGLE) begin
            w_tag_count = &r_tag_count ? r_tag_count : r_tag_count + 16'd1;
            w_pending   = w_pend_dec;
            w_coll_run  = '0;
            w_idle_run  = '0;
            w_cmd_head  = CMD_QUERYREP;
          end else if (w_res == RES_IDLE) begin
            w_coll_run = '0;
            // SHRINK only makes sense while at least two slots remain.
            if (w_idle_inc >= IW'(IDLE_LIMIT) && r_pending >= 15'd2) begin
              w_cmd_head = CMD_SHRINK;
              w_pending  = w_pend_half;
              w_idle_run = '0;
            end else begin
              w_cmd_head = CMD_QUERYREP;
              w_pending  = w_pend_dec;
              w_idle_run = w_idle_inc;
            end
          end else begin
            w_idle_run = '0;
            w_cmd_head = w_coll_inc >= CW'(COLL_LIMIT) ? CMD_DISPERSE : CMD_DIVIDE;
            w_pending  = w_coll_inc >= CW'(COLL_LIMIT) ? w_pend_dbl : w_pend_inc;
            w_coll_run = w_coll_inc >= CW'(COLL_LIMIT) ? '0 : w_coll_inc;
          end
          // An empty slot population ends the round; cmd_head keeps the decided code unissued.
          w_state     = w_pending == '0 ? ST_DONE : ST_ISSUE;
          w_cmd_valid = w_pending != '0;
          w_done      = w_pending == '0;
        end
        ST_DONE: w_state = ST_IDLE;
        default: w_state = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_head  <= 8'h00;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_tag_count <= '0;
      r_pending   <= '0;
      r_coll_run  <= '0;
      r_idle_run  <= '0;
      r_result    <= SR_IDLE;
    end else begin
      r_state     <= w_state;
      r_cmd_valid <= w_cmd_valid;
      r_cmd_head  <= w_cmd_head;
      r_done      <= w_done;
      r_busy      <= w_state != ST_IDLE;
      r_tag_count <= w_tag_count;
      r_pending   <= w_pending;
      r_coll_run  <= w_coll_run;
      r_idle_run  <= w_idle_run;
      r_result    <= w_result;
    end
  end
  assign bus.cmd_valid       = r_cmd_valid;
  assign bus.cmd_head        = r_cmd_head;
  assign bus.divide_position = 1'b0;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.tag_count       = r_tag_count;
  assign bus.pending         = r_pending;
endmodule

// File: tb/tb_reader_slot_ctrl.sv
// tb_reader_slot_ctrl: table-driven rounds plus handshake/timeout, abort and reset sequences
module tb_reader_slot_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  reader_slot_ctrl_if bus();
  reader_slot_ctrl #(.COLL_LIMIT(3), .IDLE_LIMIT(3), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit         newr;
    logic [1:0] res;
    logic [7:0] cmd;
    logic [14:0] pend;
    logic [15:0] tags;
    bit         fin;
  } step_t;
  step_t tv[16];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_state(input string name, input logic cv, input logic [7:0] ch,
                              input logic [14:0] pn, input logic [15:0] tc, input logic bz, input logic dn);
    chk({name, ".cmd_valid"}, 32'(bus.cmd_valid), 32'(cv));
    chk({name, ".cmd_head"}, 32'(bus.cmd_head), 32'(ch));
    chk({name, ".pending"}, 32'(bus.pending), 32'(pn));
    chk({name, ".tag_count"}, 32'(bus.tag_count), 32'(tc));
    chk({name, ".busy"}, 32'(bus.busy), 32'(bz));
    chk({name, ".done"}, 32'(bus.done), 32'(dn));
  endtask
  task automatic start_round();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_state("start", 1'b1, 8'h01, 15'd1, 16'd0, 1'b1, 1'b0);
  endtask
  task automatic handshake();
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
  endtask
  task automatic respond(input logic [1:0] r);
    bus.result_valid = 1'b1;
    bus.slot_result  = r;
    tick();
    bus.result_valid = 1'b0;
    bus.slot_result  = 2'b00;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.result_valid = 1'b0;
    bus.slot_result = 2'b00;
    // single tag
    tv[0]  = '{1'b1, 2'b01, 8'h02, 15'd0, 16'd1, 1'b1};
    // two tags, collision coded as 11
    tv[1]  = '{1'b1, 2'b11, 8'h03, 15'd2, 16'd0, 1'b0};
    tv[2]  = '{1'b0, 2'b01, 8'h02, 15'd1, 16'd1, 1'b0};
    tv[3]  = '{1'b0, 2'b01, 8'h02, 15'd0, 16'd2, 1'b1};
    // collision escalation to DISPERSE, then idle escalation to SHRINK
    tv[4]  = '{1'b1, 2'b10, 8'h03, 15'd2, 16'd0, 1'b0};
    tv[5]  = '{1'b0, 2'b10, 8'h03, 15'd3, 16'd0, 1'b0};
    tv[6]  = '{1'b0, 2'b10, 8'h04, 15'd6, 16'd0, 1'b0};
    tv[7]  = '{1'b0, 2'b00, 8'h02, 15'd5, 16'd0, 1'b0};
    tv[8]  = '{1'b0, 2'b00, 8'h02, 15'd4, 16'd0, 1'b0};
    tv[9]  = '{1'b0, 2'b00, 8'h05, 15'd2, 16'd0, 1'b0};
    tv[10] = '{1'b0, 2'b01, 8'h02, 15'd1, 16'd1, 1'b0};
    tv[11] = '{1'b0, 2'b01, 8'h02, 15'd0, 16'd2, 1'b1};
    // idle limit reached with pending<2 gives QUERYREP, not SHRINK
    tv[12] = '{1'b1, 2'b10, 8'h03, 15'd2, 16'd0, 1'b0};
    tv[13] = '{1'b0, 2'b10, 8'h03, 15'd3, 16'd0, 1'b0};
    tv[14] = '{1'b0, 2'b00, 8'h02, 15'd2, 16'd0, 1'b0};
    tv[15] = '{1'b0, 2'b00, 8'h02, 15'd1, 16'd0, 1'b0};
    tick();
    expect_state("reset", 1'b0, 8'h00, 15'd0, 16'd0, 1'b0, 1'b0);
    chk("reset.divide_position", 32'(bus.divide_position), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (tv[i].newr) start_round();
      handshake();
      respond(tv[i].res);
      tick();
      expect_state($sformatf("step%0d", i), !tv[i].fin, tv[i].cmd, tv[i].pend, tv[i].tags, 1'b1, tv[i].fin);
      chk($sformatf("step%0d.divide_position", i), 32'(bus.divide_position), 32'd0);
      if (tv[i].fin) begin
        tick();
        expect_state($sformatf("step%0d.idle", i), 1'b0, tv[i].cmd, 15'd0, tv[i].tags, 1'b0, 1'b0);
      end
    end
    // last idle of the pending<2 round ends it
    handshake();
    respond(2'b00);
    tick();
    expect_state("idle3_fin", 1'b0, 8'h02, 15'd0, 16'd0, 1'b1, 1'b1);
    tick();
    expect_state("idle3_idle", 1'b0, 8'h02, 15'd0, 16'd0, 1'b0, 1'b0);
    // cmd_ready low: head stable, start and stray results ignored
    start_round();
    for (int c = 0; c < 10; c++) begin
      bus.start = (c == 3);
      bus.result_valid = 1'b1;
      bus.slot_result = 2'b01;
      tick();
      expect_state($sformatf("hold%0d", c), 1'b1, 8'h01, 15'd1, 16'd0, 1'b1, 1'b0);
    end
    bus.start = 1'b0;
    bus.result_valid = 1'b0;
    bus.slot_result = 2'b00;
    handshake();
    repeat (63) tick();
    expect_state("wait63", 1'b0, 8'h01, 15'd1, 16'd0, 1'b1, 1'b0);
    tick();
    expect_state("wait64", 1'b0, 8'h01, 15'd1, 16'd0, 1'b1, 1'b0);
    tick();
    expect_state("timeout_idle", 1'b0, 8'h02, 15'd0, 16'd0, 1'b1, 1'b1);
    tick();
    expect_state("timeout_end", 1'b0, 8'h02, 15'd0, 16'd0, 1'b0, 1'b0);
    // abort in WAIT_RESP beats a simultaneous result
    start_round();
    handshake();
    respond(2'b10);
    tick();
    expect_state("ab_div", 1'b1, 8'h03, 15'd2, 16'd0, 1'b1, 1'b0);
    handshake();
    respond(2'b01);
    tick();
    expect_state("ab_qr", 1'b1, 8'h02, 15'd1, 16'd1, 1'b1, 1'b0);
    handshake();
    bus.abort = 1'b1;
    bus.result_valid = 1'b1;
    bus.slot_result = 2'b01;
    tick();
    bus.abort = 1'b0;
    bus.result_valid = 1'b0;
    bus.slot_result = 2'b00;
    expect_state("abort", 1'b0, 8'h02, 15'd1, 16'd1, 1'b0, 1'b0);
    tick();
    expect_state("abort_after", 1'b0, 8'h02, 15'd1, 16'd1, 1'b0, 1'b0);
    // asynchronous reset mid-round
    start_round();
    handshake();
    respond(2'b10);
    tick();
    expect_state("rst_pre", 1'b1, 8'h03, 15'd2, 16'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("rst_async", 1'b0, 8'h00, 15'd0, 16'd0, 1'b0, 1'b0);
    chk("rst_async.divide_position", 32'(bus.divide_position), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_state($sformatf("rst_rel%0d", k), 1'b0, 8'h00, 15'd0, 16'd0, 1'b0, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
